// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM control/data bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
);
  logic                  r0_req, r1_req;
  logic                  r0_we, r1_we;
  logic [ADDR_WIDTH-1:0] r0_addr, r1_addr;
  logic [DATA_WIDTH-1:0] r0_wdata, r1_wdata;
  logic                  r0_gnt, r1_gnt;
  logic                  r0_rvalid, r1_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata, r1_rdata;
  logic                  sram_csb, sram_wsb;
  logic [ADDR_WIDTH-1:0] sram_waddr, sram_raddr;
  logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, sram_rdata,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           sram_csb, sram_wsb, sram_waddr, sram_raddr, sram_wdata
  );
  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, sram_rdata,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           sram_csb, sram_wsb, sram_waddr, sram_raddr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-requester arbiter for one SRAM; define SRAM_ARB_DUAL_ISSUE_EN to co-issue a read/write pair
module sram_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
) (
  input logic            clk,
  input logic            rst_n,
  sram_arbiter_if.slave  bus
);
  logic                  prio;
  logic [1:0]            rd_pend;
  logic                  dual, g0, g1, w0, w1, rd0, rd1;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef SRAM_ARB_DUAL_ISSUE_EN
  assign dual = bus.r0_req & bus.r1_req & (bus.r0_we ^ bus.r1_we);
`else
  assign dual = 1'b0;
`endif
  // grant decision and SRAM drive; a held reset forces the idle pattern
  always_comb begin
    g0 = rst_n & bus.r0_req & (~bus.r1_req | dual | ~prio);
    g1 = rst_n & bus.r1_req & (~bus.r0_req | dual | prio);
    w0 = g0 & bus.r0_we;
    w1 = g1 & bus.r1_we;
    rd0 = g0 & ~bus.r0_we;
    rd1 = g1 & ~bus.r1_we;
    waddr = w0 ? bus.r0_addr : w1 ? bus.r1_addr : '0;
    wdata = w0 ? bus.r0_wdata : w1 ? bus.r1_wdata : '0;
    raddr = rd0 ? bus.r0_addr : rd1 ? bus.r1_addr : '0;
  end
  assign bus.r0_gnt     = g0;
  assign bus.r1_gnt     = g1;
  assign bus.sram_csb   = ~(g0 | g1);
  assign bus.sram_wsb   = ~(w0 | w1);
  assign bus.sram_waddr = waddr;
  assign bus.sram_wdata = wdata;
  assign bus.sram_raddr = raddr;
  assign bus.r0_rvalid  = rd_pend[0] & rst_n;
  assign bus.r1_rvalid  = rd_pend[1] & rst_n;
  assign bus.r0_rdata   = bus.sram_rdata;
  assign bus.r1_rdata   = bus.sram_rdata;
  // priority flips only on a single grant; read tags mark whose data returns next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      rd_pend <= 2'b00;
    end else begin
      prio    <= (g0 ^ g1) ? g0 : prio;
      rd_pend <= {rd1, rd0};
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus, behavioural SRAM, and a cycle-by-cycle reference model check
module tb_sram_arbiter;
  localparam int DW = 512;
  localparam int AW = 6;
`ifdef SRAM_ARB_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(int i);
    return {16{(32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F}};
  endfunction
  function automatic logic [DW-1:0] dv(int i);
    return {16{32'hD00D0000 + 32'(i)}};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      bus.sram_rdata <= '0;
    end else if (!bus.sram_csb) begin
      bus.sram_rdata <= mem[bus.sram_raddr];
      if (!bus.sram_wsb) mem[bus.sram_waddr] <= bus.sram_wdata;
    end
  end

  logic          m0, m1, ew;
  logic [AW-1:0] ewa, era;
  logic [DW-1:0] ewd;
  logic          prio_m = 1'b0;
  logic [1:0]    pend_m = 2'b00;
  logic [DW-1:0] dm [2];
  logic [DW-1:0] shadow [64];
  always @(negedge clk) begin
    if (!rst_n) begin
      m0 = 1'b0;
      m1 = 1'b0;
    end else if (bus.r0_req && bus.r1_req) begin
      if (DUAL && bus.r0_we != bus.r1_we) begin
        m0 = 1'b1;
        m1 = 1'b1;
      end else begin
        m0 = !prio_m;
        m1 = prio_m;
      end
    end else begin
      m0 = bus.r0_req;
      m1 = bus.r1_req;
    end
    ew = 1'b0;
    ewa = '0;
    ewd = '0;
    era = '0;
    if (m0 && bus.r0_we) begin ew = 1'b1; ewa = bus.r0_addr; ewd = bus.r0_wdata; end
    if (m1 && bus.r1_we) begin ew = 1'b1; ewa = bus.r1_addr; ewd = bus.r1_wdata; end
    if (m0 && !bus.r0_we) era = bus.r0_addr;
    if (m1 && !bus.r1_we) era = bus.r1_addr;
    chk("m_gnt", {bus.r1_gnt, bus.r0_gnt}, {m1, m0});
    chk("m_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, rst_n ? pend_m : 2'b00);
    if (rst_n && pend_m[0]) chk("m_r0_rdata", bus.r0_rdata, dm[0]);
    if (rst_n && pend_m[1]) chk("m_r1_rdata", bus.r1_rdata, dm[1]);
    chk("m_csb", bus.sram_csb, !(m0 || m1));
    chk("m_wsb", bus.sram_wsb, !ew);
    chk("m_waddr", bus.sram_waddr, ewa);
    chk("m_wdata", bus.sram_wdata, ewd);
    chk("m_raddr", bus.sram_raddr, era);
    if (!rst_n) begin
      prio_m = 1'b0;
      pend_m = 2'b00;
      for (int i = 0; i < 64; i++) shadow[i] = pat(i);
    end else begin
      pend_m = {m1 && !bus.r1_we, m0 && !bus.r0_we};
      if (pend_m[0]) dm[0] = shadow[bus.r0_addr];
      if (pend_m[1]) dm[1] = shadow[bus.r1_addr];
      if (ew) shadow[ewa] = ewd;
      if (m0 != m1) prio_m = m0;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 6'd1; bus.r0_wdata = '0;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 6'd2; bus.r1_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("rst_gnt", {bus.r1_gnt, bus.r0_gnt}, 2'b00);
      chk("rst_csb", bus.sram_csb, 1'b1);
      chk("rst_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b00);
      next();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      look();
      chk("cont_gnt", {bus.r1_gnt, bus.r0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("cont_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, (i % 2) ? 2'b01 : 2'b10);
      if (i % 2 == 1) chk("cont_r0_rdata", bus.r0_rdata, pat(1));
      if (i > 0 && i % 2 == 0) chk("cont_r1_rdata", bus.r1_rdata, pat(2));
      next();
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    look();
    chk("idle_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b10);
    chk("idle_csb", bus.sram_csb, 1'b1);
    next();
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 6'd5; bus.r0_wdata = {64{8'hA5}};
    look();
    chk("wr_gnt", bus.r0_gnt, 1'b1);
    chk("wr_wsb", bus.sram_wsb, 1'b0);
    next();
    bus.r0_req = 1'b0; bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 6'd5;
    look();
    chk("rd_gnt", bus.r1_gnt, 1'b1);
    next();
    bus.r1_req = 1'b0;
    look();
    chk("rd_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b10);
    chk("rd_rdata", bus.r1_rdata, {64{8'hA5}});
    next();
    bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 6'd3; bus.r1_wdata = {64{8'h3C}};
    look();
    chk("pre_gnt", bus.r1_gnt, 1'b1);
    next();
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 6'd3; bus.r0_wdata = {64{8'hC3}};
    bus.r1_we = 1'b0;
    look();
`ifdef SRAM_ARB_DUAL_ISSUE_EN
    chk("pair_gnt", {bus.r1_gnt, bus.r0_gnt}, 2'b11);
    chk("pair_wsb", bus.sram_wsb, 1'b0);
    next();
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    look();
    chk("pair_rvalid", bus.r1_rvalid, 1'b1);
    chk("pair_old", bus.r1_rdata, {64{8'h3C}});
    next();
    bus.r1_req = 1'b1;
    look();
    chk("reread_gnt", bus.r1_gnt, 1'b1);
    next();
    bus.r1_req = 1'b0;
    look();
    chk("reread_rdata", bus.r1_rdata, {64{8'hC3}});
    next();
`else
    chk("pair_gnt", {bus.r1_gnt, bus.r0_gnt}, 2'b01);
    next();
    bus.r0_req = 1'b0;
    look();
    chk("pair_gnt2", {bus.r1_gnt, bus.r0_gnt}, 2'b10);
    next();
    bus.r1_req = 1'b0;
    look();
    chk("pair_rvalid", bus.r1_rvalid, 1'b1);
    chk("pair_new", bus.r1_rdata, {64{8'hC3}});
    next();
`endif
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 6'd7;
    look();
    chk("mid_gnt", bus.r1_gnt, 1'b1);
    next();
    rst_n = 1'b0; bus.r1_req = 1'b0;
    look();
    chk("mid_rvalid1", bus.r1_rvalid, 1'b0);
    next();
    rst_n = 1'b1;
    look();
    chk("mid_rvalid2", bus.r1_rvalid, 1'b0);
    next();
    for (int i = 0; i < 4; i++) begin
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 6'(i); bus.r0_wdata = dv(i);
      look();
      chk("b2b_gnt", bus.r0_gnt, 1'b1);
      chk("b2b_wsb", bus.sram_wsb, 1'b0);
      next();
    end
    for (int k = 0; k < 5; k++) begin
      bus.r0_req = (k < 4); bus.r0_we = 1'b0; bus.r0_addr = 6'(k % 4);
      look();
      if (k < 4) chk("rb_gnt", bus.r0_gnt, 1'b1);
      if (k > 0) begin
        chk("rb_rvalid", bus.r0_rvalid, 1'b1);
        chk("rb_rdata", bus.r0_rdata, dv(k - 1));
      end
      next();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one single-ported-chip-select `sram` instance between a loader and a compute engine. It performs round-robin arbitration and drives the SRAM's active-low `csb`/`wsb` controls. It returns read data to the requester that issued each read, with a per-requester valid strobe. It sits directly in front of each operand/result SRAM in the coaccelerator datapath.

## Interface
- `DATA_WIDTH`, 512: SRAM word width; must match the attached `sram`.
- `ADDR_WIDTH`, 6: SRAM address width; depth = 2^ADDR_WIDTH.

- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `r0_req`, `r1_req`  in  1  access request; held with its payload stable until granted.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_WIDTH  word address.
- `r0_wdata`, `r1_wdata`  in  DATA_WIDTH  write data; ignored on reads.
- `r0_gnt`, `r1_gnt`  out  1  combinational grant; the transfer occurs in a cycle where `req && gnt`.
- `r0_rvalid`, `r1_rvalid`  out  1  registered; read data valid this cycle.
- `r0_rdata`, `r1_rdata`  out  DATA_WIDTH  both driven directly from `sram_rdata`.
- `sram_csb`, `sram_wsb`  out  1  to SRAM `csb`/`wsb`; active-low.
- `sram_waddr`, `sram_raddr`  out  ADDR_WIDTH  to SRAM.
- `sram_wdata`  out  DATA_WIDTH  to SRAM.
- `sram_rdata`  in  DATA_WIDTH  from SRAM; valid 1 cycle after a `csb`-low cycle.

## Operation
- **State registers:**
  - `prio`: 0 = r0 favoured, 1 = r1 favoured.
  - `rd_pend[1:0]`: read issued last cycle, one bit per requester.
- **Single grant:**
  - If exactly one `req` is high, that requester is granted.
  - If both are high, the requester selected by `prio` is granted.
  - After any single grant, `prio` points to the other requester.
  - A cycle with no grant leaves `prio` unchanged.
- **SRAM drive on a granted cycle:** `sram_csb=0`.
  - Write: `sram_wsb=0`, `sram_waddr`/`sram_wdata` taken from the winner, `sram_raddr=0`.
  - Read: `sram_wsb=1`, `sram_raddr` taken from the winner, `sram_waddr=0`, `sram_wdata=0`.
- **Idle cycle:** `sram_csb=1`, `sram_wsb=1`, all SRAM address and data outputs 0.
- **Read return:** `rd_pend[i]` is set on the grant cycle of a read by requester i. Next cycle, `ri_rvalid=1` and `ri_rdata` holds the addressed word.
- **Write-only grants:** a write-only grant performs a dummy read of address 0. It never raises `rvalid`.
- **Reset:**
  - While `rst_n=0`: both `gnt=0`, `sram_csb=1`, `sram_wsb=1`.
  - On the next edge: `prio=0`, `rd_pend=0`.
  - A pending read response is dropped, so `rvalid` stays 0 if reset hits between grant and return.
- **Back-to-back:** a requester may be granted on consecutive cycles whenever the other is not requesting. There are no bubble cycles.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from `req`, `we` and `prio`.
- Read latency is exactly 1 cycle, grant to `rvalid`.
- `rvalid` is a 1-cycle pulse per granted read.
- `rdata` is only defined while its `rvalid` is high.
- Worst-case wait under continuous contention, single-issue, is 1 cycle.
- A same-cycle read and write to the same address returns the OLD word. The SRAM latches read data before the write lands.
- Reset outputs: `r0_gnt=r1_gnt=0`, `r0_rvalid=r1_rvalid=0`, `sram_csb=1`, `sram_wsb=1`, `sram_waddr=sram_raddr=0`, `sram_wdata=0`.

## Configuration
- Macro: `SRAM_ARB_DUAL_ISSUE_EN`.
- **Defined:**
  - If both request and exactly one is a write, both are granted in the same cycle. `sram_csb=0`, `sram_wsb=0`, `waddr`/`wdata` come from the writer, `raddr` from the reader.
  - `prio` is unchanged on a dual-issue cycle.
  - A same-address pair gives the reader the old data.
- **Undefined:** one grant per cycle in all cases. A read/write pair is serialized per `prio`.
- Two reads or two writes are always serialized, regardless of the macro.

## Test plan
- **Reset:**
  - Stimulus: `rst_n=0` for 3 cycles with both `req=1`.
  - Required: `gnt=00`, `sram_csb=1`, `rvalid=00` every cycle. The first grant after release goes to r0.
- **Write then read:**
  - Stimulus: r0 writes `addr=5` data `0xA5…A5`. Next cycle r1 reads `addr=5`.
  - Required: `r1_gnt` in cycle N+1, `r1_rvalid=1` in cycle N+2 with `r1_rdata=0xA5…A5`. `r0_rvalid` stays 0.
- **Contention:**
  - Stimulus: both hold read requests for 6 cycles, addresses 1 and 2.
  - Required: grants r0,r1,r0,r1,r0,r1. Each `rvalid` one cycle after its grant, carrying the matching word.
- **Same-address read/write pair:**
  - Stimulus: `mem[3]=A`. In the same cycle, r0 writes `addr=3` data `B` and r1 reads `addr=3`.
  - With the macro: both granted, r1 gets `A`, and a re-read gets `B`.
  - Without the macro: r0 is granted first, then r1, and r1 gets `B`.
- **Reset mid-read:**
  - Stimulus: r1 read granted in cycle N, `rst_n=0` in cycle N+1.
  - Required: `r1_rvalid=0` in N+1 and N+2.
- **Single writer, back-to-back:**
  - Stimulus: r0 alone writes addresses 0..3 on 4 consecutive cycles.
  - Required: `gnt` high 4 cycles, `sram_wsb=0` each cycle. Read-back of 0..3 returns the written data.
